qoi_decoder: RTL and testbench

//  Streaming QOI chunk decoder; the receive-side counterpart of qoi_encoder. Consumes one chunk per

---
 rtl/qoi_decoder_if.sv | 23 ++
 rtl/qoi_decoder.sv | 164 ++++++++++++++++
 tb/tb_qoi_decoder.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/qoi_decoder_if.sv
// Chunk-in / pixel-out stream bundle for qoi_decoder.
// master: chunk source and pixel sink. slave: the decoder.
interface qoi_decoder_if;
    logic [31:0] chunk;
    logic [2:0]  chunk_bytes;
    logic        chunk_valid;
    logic        chunk_ready;
    logic [7:0]  r;
    logic [7:0]  g;
    logic [7:0]  b;
    logic        px_valid;
    logic        px_ready;

    modport master (
        output chunk, chunk_bytes, chunk_valid, px_ready,
        input  chunk_ready, r, g, b, px_valid
    );

    modport slave (
        input  chunk, chunk_bytes, chunk_valid, px_ready,
        output chunk_ready, r, g, b, px_valid
    );
endinterface

// File: rtl/qoi_decoder.sv
// Streaming QOI chunk decoder: one chunk per accepted beat, one RGB pixel per output beat.
// QOI_OP_RUN chunks are expanded here while the chunk input is stalled.
// Optional feature macro QOI_DECODER_INDEX_EN: adds the 64-entry colour index and its hash.
// Without it an INDEX chunk re-emits the previous pixel and raises err.
module qoi_decoder #(
    parameter int unsigned RUN_MAX = 62
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    qoi_decoder_if.slave bus,
    output logic         err
);
    typedef enum logic [0:0] {StAccept, StRun} state_e;

    state_e      state_q;
    logic [5:0]  run_left_q;
    // The output register doubles as the previous pixel: every emit loads both identically.
    logic [7:0]  r_q, g_q, b_q;
    logic        px_valid_q;
    logic        err_q;

    logic        adv, accept, take, run_emit, emit;
    logic [7:0]  b0, b1, dg;
    logic [2:0]  op_len;
    logic        dec_emit, dec_err, dec_run;
    logic [7:0]  dec_r, dec_g, dec_b;
    logic [7:0]  emit_r, emit_g, emit_b;

`ifdef QOI_DECODER_INDEX_EN
    // Alpha is always 255 here, so only RGB is stored and its hash term is a constant.
    localparam logic [9:0] AlphaHash = 10'(11 * 255);
    logic [23:0] index_q [64];
    logic [9:0]  hash;
`endif

    assign adv             = !px_valid_q || bus.px_ready;
    assign bus.chunk_ready = (state_q == StAccept) && adv;
    assign accept          = bus.chunk_valid && bus.chunk_ready;
    // Zero-length chunks are bubbles: consumed, no pixel, no error.
    assign take            = accept && (bus.chunk_bytes != 3'd0);
    assign run_emit        = (state_q == StRun) && adv;
    assign emit            = run_emit || (take && dec_emit);
    assign emit_r          = run_emit ? r_q : dec_r;
    assign emit_g          = run_emit ? g_q : dec_g;
    assign emit_b          = run_emit ? b_q : dec_b;

    // Decode the chunk on the bus into a pixel, its expected length and error flag.
    always_comb begin
        b0       = bus.chunk[31:24];
        b1       = bus.chunk[23:16];
        dec_r    = r_q;
        dec_g    = g_q;
        dec_b    = b_q;
        dg       = 8'h00;
        op_len   = 3'd1;
        dec_emit = 1'b1;
        dec_err  = 1'b0;
        dec_run  = 1'b0;
        if (b0 == 8'hFE) begin
            op_len                = 3'd4;
            {dec_r, dec_g, dec_b} = bus.chunk[23:0];
        end else if (b0 == 8'hFF) begin
            // RGBA cannot be represented on an RGB output.
            op_len   = 3'd5;
            dec_emit = 1'b0;
            dec_err  = 1'b1;
        end else begin
            case (b0[7:6])
                2'b11: begin
                    dec_run = (b0[5:0] != 6'd0);
                    if (32'(b0[5:0]) >= RUN_MAX) dec_err = 1'b1;
                end
                2'b00: begin
`ifdef QOI_DECODER_INDEX_EN
                    {dec_r, dec_g, dec_b} = index_q[b0[5:0]];
`else
                    dec_err = 1'b1;
`endif
                end
                2'b01: begin
                    dec_r = r_q + {6'd0, b0[5:4]} - 8'd2;
                    dec_g = g_q + {6'd0, b0[3:2]} - 8'd2;
                    dec_b = b_q + {6'd0, b0[1:0]} - 8'd2;
                end
                default: begin
                    op_len = 3'd2;
                    dg     = {2'd0, b0[5:0]} - 8'd32;
                    dec_g  = g_q + dg;
                    dec_r  = r_q + dg + {4'd0, b1[7:4]} - 8'd8;
                    dec_b  = b_q + dg + {4'd0, b1[3:0]} - 8'd8;
                end
            endcase
        end
        if (bus.chunk_bytes != op_len) dec_err = 1'b1;
    end

    // Control FSM plus registered pixel, valid and sticky error.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StAccept;
            run_left_q <= 6'd0;
            r_q        <= 8'h00;
            g_q        <= 8'h00;
            b_q        <= 8'h00;
            px_valid_q <= 1'b0;
            err_q      <= 1'b0;
        end else if (clear) begin
            state_q    <= StAccept;
            run_left_q <= 6'd0;
            r_q        <= 8'h00;
            g_q        <= 8'h00;
            b_q        <= 8'h00;
            px_valid_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            if (emit) begin
                r_q        <= emit_r;
                g_q        <= emit_g;
                b_q        <= emit_b;
                px_valid_q <= 1'b1;
            end else if (bus.px_ready) begin
                px_valid_q <= 1'b0;
            end
            if (take && dec_err) err_q <= 1'b1;
            case (state_q)
                StAccept: begin
                    if (take && dec_run) begin
                        state_q    <= StRun;
                        run_left_q <= b0[5:0];
                    end
                end
                StRun: begin
                    if (adv) begin
                        run_left_q <= run_left_q - 6'd1;
                        if (run_left_q == 6'd1) state_q <= StAccept;
                    end
                end
                default: state_q <= StAccept;
            endcase
        end
    end

`ifdef QOI_DECODER_INDEX_EN
    assign hash = 10'(emit_r) * 10'd3 + 10'(emit_g) * 10'd5 + 10'(emit_b) * 10'd7 + AlphaHash;

    // Colour index: every emitted pixel is written at its hash slot.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 64; i++) index_q[i] <= 24'h0;
        end else if (clear) begin
            for (int i = 0; i < 64; i++) index_q[i] <= 24'h0;
        end else if (emit) begin
            index_q[hash[5:0]] <= {emit_r, emit_g, emit_b};
        end
    end
`endif

    assign bus.r        = r_q;
    assign bus.g        = g_q;
    assign bus.b        = b_q;
    assign bus.px_valid = px_valid_q;
    assign err          = err_q;
endmodule

// File: tb/tb_qoi_decoder.sv
// Directed bench for qoi_decoder: hand-computed pixels for each op, run expansion, errors.
module tb_qoi_decoder;
    logic clk = 1'b0;
    logic rst;
    logic clear;
    logic err;
    int   checks = 0;
    int   errors = 0;
    int   n_px, n_busy;
    logic [31:0] exp_idx_px, exp_idx_err;

    qoi_decoder_if bus ();

    qoi_decoder dut (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .bus   (bus),
        .err   (err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pix();
        return {8'h00, bus.r, bus.g, bus.b};
    endfunction

    // Offer one chunk until accepted (bounded); returns 1 ns after the accepting edge.
    task automatic push(input logic [31:0] c, input logic [2:0] n);
        int waited = 0;
        bus.chunk       = c;
        bus.chunk_bytes = n;
        bus.chunk_valid = 1'b1;
        #1;
        while (!bus.chunk_ready && waited < 50) begin
            @(posedge clk);
            #2;
            waited++;
        end
        if (!bus.chunk_ready) check_eq("push_timeout", 32'(bus.chunk_ready), 1);
        @(posedge clk);
        #1;
        bus.chunk_valid = 1'b0;
    endtask

    task automatic clear_pulse();
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
    endtask

    // Count pixel handshakes and busy cycles over a window, checking each handed-off pixel.
    task automatic drain(input int cycles, input bit toggle, input logic [31:0] exp_px,
                         output int np, output int nb);
        np = 0;
        nb = 0;
        for (int i = 0; i < cycles; i++) begin
            bus.px_ready = toggle ? ~i[0] : 1'b1;
            #1;
            if (!bus.chunk_ready) nb++;
            if (bus.px_valid && bus.px_ready) begin
                np++;
                check_eq("run_px", pix(), exp_px);
            end
            @(posedge clk);
            #1;
        end
        bus.px_ready = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog checks %0d errors %0d", checks, errors);
        $fatal(1, "timeout");
    end

    initial begin
        rst             = 1'b0;
        clear           = 1'b0;
        bus.chunk       = 32'h0;
        bus.chunk_bytes = 3'd0;
        bus.chunk_valid = 1'b0;
        bus.px_ready    = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Reset state
        check_eq("rst_valid", 32'(bus.px_valid), 0);
        check_eq("rst_err", 32'(err), 0);
        check_eq("rst_px", pix(), 32'h000000);
        check_eq("rst_ready", 32'(bus.chunk_ready), 1);

        // RGB, then DIFF -2 and +1
        push(32'hFE102030, 3'd4);
        check_eq("rgb_valid", 32'(bus.px_valid), 1);
        check_eq("rgb_px", pix(), 32'h102030);
        push(32'h40000000, 3'd1);
        check_eq("diff_m2", pix(), 32'h0E1E2E);
        push(32'h7F000000, 3'd1);
        check_eq("diff_p1", pix(), 32'h0F1F2F);
        check_eq("diff_err", 32'(err), 0);

        // LUMA with wrap from black
        clear_pulse();
        check_eq("clr_valid", 32'(bus.px_valid), 0);
        push(32'h80000000, 3'd2);
        check_eq("luma_px", pix(), 32'hD8E0D8);
        check_eq("luma_err", 32'(err), 0);

        // RUN 3 -> 4 pixels, input stalled 3 cycles
        push(32'hC3000000, 3'd1);
        drain(8, 1'b0, 32'hD8E0D8, n_px, n_busy);
        check_eq("run_count", 32'(n_px), 4);
        check_eq("run_busy", 32'(n_busy), 3);
        check_eq("run_idle", 32'(bus.px_valid), 0);

        // Same run with back-pressure
        push(32'hFE112233, 3'd4);
        push(32'hC3000000, 3'd1);
        drain(16, 1'b1, 32'h112233, n_px, n_busy);
        check_eq("run_bp_count", 32'(n_px), 4);
        check_eq("run_bp_ready", 32'(bus.chunk_ready), 1);

        // INDEX: (10,20,30) hashes to slot 21
        clear_pulse();
        push(32'hFE102030, 3'd4);
        push(32'hFEAABBCC, 3'd4);
        push(32'h15000000, 3'd1);
`ifdef QOI_DECODER_INDEX_EN
        exp_idx_px  = 32'h102030;
        exp_idx_err = 32'd0;
`else
        exp_idx_px  = 32'hAABBCC;
        exp_idx_err = 32'd1;
`endif
        check_eq("index_px", pix(), exp_idx_px);
        check_eq("index_err", 32'(err), exp_idx_err);

        // Bubble, length mismatch, RGBA
        clear_pulse();
        push(32'hFE010203, 3'd4);
        push(32'h40000000, 3'd0);
        check_eq("bubble_valid", 32'(bus.px_valid), 0);
        check_eq("bubble_err", 32'(err), 0);
        push(32'h40000000, 3'd2);
        check_eq("badlen_px", pix(), 32'hFF0001);
        check_eq("badlen_valid", 32'(bus.px_valid), 1);
        check_eq("badlen_err", 32'(err), 1);
        clear_pulse();
        check_eq("clr_err", 32'(err), 0);
        push(32'hFF000000, 3'd5);
        check_eq("rgba_valid", 32'(bus.px_valid), 0);
        check_eq("rgba_err", 32'(err), 1);

        // Clear in the middle of a run
        clear_pulse();
        push(32'hC5000000, 3'd1);
        check_eq("midrun_busy", 32'(bus.chunk_ready), 0);
        clear_pulse();
        check_eq("abort_valid", 32'(bus.px_valid), 0);
        check_eq("abort_ready", 32'(bus.chunk_ready), 1);
        check_eq("abort_err", 32'(err), 0);
        @(posedge clk);
        #1;
        check_eq("abort_quiet", 32'(bus.px_valid), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
